// File: rtl/dram_port_arbiter_if.sv
// One requester's access port into the shared 256x1 LUT-RAM.
// master = requester side, slave = arbiter side.
interface dram_port_arbiter_if;
   logic       req;
   logic       we;
   logic [7:0] addr;
   logic       wdata;
   logic       gnt;
   logic       rvalid;
   logic       rdata;

   modport master (
      output req, we, addr, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, wdata,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/dram_port_arbiter.sv
// Round-robin sharing of one 256x1 dual-port LUT-RAM between requesters A and B,
// with an optional post-reset clear sweep and registered read data.
module dram_port_arbiter #(
   parameter logic [255:0] INIT           = 256'b0,
   parameter bit           CLEAR_ON_RESET = 1'b1,
   parameter logic         CLEAR_VAL      = 1'b0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   dram_port_arbiter_if.slave        a,
   dram_port_arbiter_if.slave        b,
   input  logic [7:0]                mon_addr,
   output logic                      mon_data,
   output logic                      busy
);

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_RUN   = 1'b1;
   localparam logic       ID_A     = 1'b0;
   localparam logic       ID_B     = 1'b1;

   logic [0:0] state_reg, state_next;
   logic [7:0] clr_addr_reg;
   logic       rr_last_reg;
   logic       a_rvalid_reg, b_rvalid_reg;
   logic       a_rdata_reg, b_rdata_reg;
   logic       mon_data_reg;

   logic       running, clearing;
   logic       a_acc, b_acc;
   logic [7:0] ram_addr;
   logic       ram_we, ram_d;
   logic       ram_spo, ram_dpo;

   // 256x1 LUT-RAM: one sync write / async read port, one async read port.
   logic [255:0] ram_bits = INIT;

   always_ff @(posedge clk) begin
      if (ram_we)
         ram_bits[ram_addr] <= ram_d;
   end

   assign ram_spo = ram_bits[ram_addr];
   assign ram_dpo = ram_bits[mon_addr];

   // Reset is level-qualified here so that nothing is granted or written while rst_n is low.
   assign running  = rst_n && (state_reg == ST_RUN);
   assign clearing = rst_n && (state_reg == ST_CLEAR);
   assign busy     = !running;

   // On conflict, the requester that did not win last time gets the port.
   assign a_acc = running && a.req && (!b.req || (rr_last_reg == ID_B));
   assign b_acc = running && b.req && (!a.req || (rr_last_reg == ID_A));

   assign a.gnt    = a_acc;
   assign b.gnt    = b_acc;
   assign a.rvalid = a_rvalid_reg;
   assign b.rvalid = b_rvalid_reg;
   assign a.rdata  = a_rdata_reg;
   assign b.rdata  = b_rdata_reg;
   assign mon_data = mon_data_reg;

   always_comb begin
      ram_addr = 8'h00;
      ram_we   = 1'b0;
      ram_d    = 1'b0;
      if (clearing) begin
         ram_addr = clr_addr_reg;
         ram_we   = 1'b1;
         ram_d    = CLEAR_VAL;
      end else if (a_acc) begin
         ram_addr = a.addr;
         ram_we   = a.we;
         ram_d    = a.wdata;
      end else if (b_acc) begin
         ram_addr = b.addr;
         ram_we   = b.we;
         ram_d    = b.wdata;
      end
   end

   always_comb begin
      state_next = state_reg;
      if (clearing && (clr_addr_reg == 8'hFF))
         state_next = ST_RUN;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
         clr_addr_reg <= 8'h00;
         rr_last_reg  <= ID_B;
         a_rvalid_reg <= 1'b0;
         b_rvalid_reg <= 1'b0;
         a_rdata_reg  <= 1'b0;
         b_rdata_reg  <= 1'b0;
         mon_data_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         mon_data_reg <= ram_dpo;
         if (clearing)
            clr_addr_reg <= clr_addr_reg + 8'd1;
         if (a_acc)
            rr_last_reg <= ID_A;
         else if (b_acc)
            rr_last_reg <= ID_B;
         a_rvalid_reg <= a_acc;
         b_rvalid_reg <= b_acc;
         // SPO is sampled at the write edge, so writes return the pre-write word.
         if (a_acc)
            a_rdata_reg <= ram_spo;
         if (b_acc)
            b_rdata_reg <= ram_spo;
      end
   end

endmodule
